masked_gf16_mult_pipe: RTL and testbench
========================================

# masked_gf16_mult_pipe

Pipelined, d+1-share masked GF(2^4) multiplier with a configurable share count and an optional constant addition. It is the sequential successor of the team's combinational bilinear GF(16) multiplier. It computes shared inputs a and b with domain-oriented cross-products, refreshes the off-diagonal terms with fresh randomness, and registers them before compression so that glitches cannot recombine shares. It sits in the masked S-box datapath, in the GF(16) inversion/multiplication layers between the linear input map and the output map.

## Interface
- SHARES, 3: number of shares per operand (d+1); legal values 2..4.
- ADD_CONSTANT, 0: 1 adds c_in to share 0 of the result in stage 2; 0 ignores c_in.
- clk  in  1  clock; all registers update on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  pipeline advance; 0 freezes every register, including valid bits.
- valid_in  in  1  a_in/b_in/r_in carry a new operation this cycle.
- a_in  in  4*SHARES  operand a shares; share i is a_in[4i+3:4i].
- b_in  in  4*SHARES  operand b shares, same packing.
- r_in  in  4*SHARES*(SHARES-1)/2  fresh randomness; one nibble per pair (i<j), packed in lexicographic pair order (0,1),(0,2),…,(1,2),….
- c_in  in  4  public constant, sampled with stage-2 data.
- valid_out  out  1  y_out holds a valid result.
- y_out  out  4*SHARES  result shares, same packing.

## Operation
- G(x,y) is the team GF(16) bilinear product on nibbles x=x0..x3 and y=y0..y3:
  - g0 = x0y0^x1y0^x2y0^x0y1^x3y1^x0y2^x2y2^x1y3^x3y3
  - g1 = x0y0^x3y0^x1y1^x2y1^x3y1^x1y2^x3y2^x0y3^x1y3^x2y3^x3y3
  - g2 = x0y0^x2y0^x1y1^x3y1^x0y2^x2y2^x3y2^x1y3^x2y3
  - g3 = x1y0^x3y0^x0y1^x1y1^x2y1^x3y1^x1y2^x2y2^x0y3^x1y3^x3y3
- Stage 1 (register p[i][j], SHARES^2 nibbles):
  - p[i][i] = G(a_i, b_i).
  - For i≠j, p[i][j] = G(a_i, b_j) ^ r(min(i,j), max(i,j)). The same mask nibble goes to both p[i][j] and p[j][i], so the masks cancel.
- Stage 2 (output register): y_i = XOR over j of p[i][j]; y_0 additionally ^ c_in when ADD_CONSTANT=1.
- Correctness: XOR of all y_i = G(XOR a_i, XOR b_i) [^ c_in].
- No combinational path mixes two shares' data before the stage-1 register. Only the XOR compression in stage 2 combines registered terms.
- Data registers load on en=1 regardless of valid. valid bits form a 2-deep shift register gated by en.
- r_in must be fresh and uniform in every cycle with valid_in=1 and en=1; it is don't-care otherwise.

## Timing
- Latency 2 cycles: valid_in=1 sampled at edge k (en=1) gives valid_out=1 and y_out after edge k+1, provided en=1 at edges k and k+1.
- Throughput: one operation per cycle; back-to-back valid_in is supported.
- en=0: all registers hold; valid_out and y_out stay constant. A held result is presented exactly once per advance and is neither duplicated nor lost.
- Reset (rst_n=0, asynchronous): p=0, y_out=0, valid_out=0, valid pipeline cleared.
- Reset mid-operation: in-flight operations are discarded. The first valid_out after deassertion comes 2 advancing cycles after a new valid_in.
- rst_n deassertion is assumed synchronised externally. The first edge after release behaves normally.
- c_in is sampled at the stage-2 edge, i.e. the edge after the one that sampled the operands.

## Test plan
- SHARES=2, a shares (3,2), b shares (5,4), r=A, en=1 → two cycles later valid_out=1 and y0^y1=7 (G(1,1)=7).
- SHARES=2, a=(2,0), b=(6,4), r=0 vs r=F → XOR of shares = E (G(2,2)) in both runs; individual y0 differs by F between runs.
- SHARES=3, ADD_CONSTANT=1, a unmasked 1, b unmasked 1, c_in=5, random shares and r → XOR of shares = 2, on every cycle of a 1000-cycle back-to-back random stream checked against the G reference model.
- Stall: valid_in on cycles 0,1,2 with en=0 during cycle 1 → exactly 3 valid_out pulses, results in order, outputs held while en=0.
- Reset mid-flight: valid_in at cycle 0, rst_n low during cycle 1 → valid_out, y_out are 0 immediately and no valid_out appears until 2 cycles after the next valid_in.
- Exhaustive: SHARES=2, all 256 (a,b) pairs with random sharing and r → recombined output equals G(a,b).

Source files
------------

// File: rtl/masked_gf16_mult_pipe.sv
// Two-stage d+1-share masked GF(16) multiplier: refreshed domain cross-products are
// registered before the per-share XOR compression, so glitches cannot recombine shares.
module masked_gf16_mult_pipe #(
   parameter int SHARES       = 3,
   parameter int ADD_CONSTANT = 0
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                en,
   input  logic                                valid_in,
   input  logic [4*SHARES-1:0]                 a_in,
   input  logic [4*SHARES-1:0]                 b_in,
   input  logic [4*SHARES*(SHARES-1)/2-1:0]    r_in,
   input  logic [3:0]                          c_in,
   output logic                                valid_out,
   output logic [4*SHARES-1:0]                 y_out
);

   localparam int NP = SHARES * SHARES;

   // Team bilinear GF(16) product on nibbles.
   function automatic logic [3:0] gf16_bilin(input logic [3:0] x, input logic [3:0] y);
      logic [3:0] g;
      g[0] = (x[0] & y[0]) ^ (x[1] & y[0]) ^ (x[2] & y[0]) ^ (x[0] & y[1]) ^ (x[3] & y[1]) ^
             (x[0] & y[2]) ^ (x[2] & y[2]) ^ (x[1] & y[3]) ^ (x[3] & y[3]);
      g[1] = (x[0] & y[0]) ^ (x[3] & y[0]) ^ (x[1] & y[1]) ^ (x[2] & y[1]) ^ (x[3] & y[1]) ^
             (x[1] & y[2]) ^ (x[3] & y[2]) ^ (x[0] & y[3]) ^ (x[1] & y[3]) ^ (x[2] & y[3]) ^
             (x[3] & y[3]);
      g[2] = (x[0] & y[0]) ^ (x[2] & y[0]) ^ (x[1] & y[1]) ^ (x[3] & y[1]) ^ (x[0] & y[2]) ^
             (x[2] & y[2]) ^ (x[3] & y[2]) ^ (x[1] & y[3]) ^ (x[2] & y[3]);
      g[3] = (x[1] & y[0]) ^ (x[3] & y[0]) ^ (x[0] & y[1]) ^ (x[1] & y[1]) ^ (x[2] & y[1]) ^
             (x[3] & y[1]) ^ (x[1] & y[2]) ^ (x[2] & y[2]) ^ (x[0] & y[3]) ^ (x[1] & y[3]) ^
             (x[3] & y[3]);
      return g;
   endfunction

   logic [4*NP-1:0]     w_p;
   logic [4*NP-1:0]     r_p;
   logic [4*SHARES-1:0] w_y;
   logic [4*SHARES-1:0] r_y;
   logic [3:0]          w_c;
   logic                r_v1;
   logic                r_v2;

   // Each term touches exactly one share of a and one of b; the pair mask is shared by (i,j) and (j,i).
   for (genvar gi = 0; gi < SHARES; gi++) begin : g_row
      for (genvar gj = 0; gj < SHARES; gj++) begin : g_col
         localparam int LO = (gi < gj) ? gi : gj;
         localparam int HI = (gi < gj) ? gj : gi;
         localparam int PI = LO * SHARES - (LO * (LO + 1)) / 2 + (HI - LO - 1);
         if (gi == gj) begin : g_diag
            assign w_p[4*(gi*SHARES+gj) +: 4] = gf16_bilin(a_in[4*gi +: 4], b_in[4*gj +: 4]);
         end else begin : g_cross
            assign w_p[4*(gi*SHARES+gj) +: 4] = gf16_bilin(a_in[4*gi +: 4], b_in[4*gj +: 4])
                                                ^ r_in[4*PI +: 4];
         end
      end
   end

   assign w_c = (ADD_CONSTANT == 1) ? c_in : 4'h0;

   // Compression: only registered terms are combined here.
   always_comb begin
      w_y = '0;
      for (int i = 0; i < SHARES; i++) begin
         for (int j = 0; j < SHARES; j++) begin
            w_y[4*i +: 4] = w_y[4*i +: 4] ^ r_p[4*(i*SHARES+j) +: 4];
         end
      end
      w_y[3:0] = w_y[3:0] ^ w_c;
   end

   // Pipeline registers; en=0 freezes data and valid alike.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p  <= '0;
         r_y  <= '0;
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
      end else if (en) begin
         r_p  <= w_p;
         r_y  <= w_y;
         r_v1 <= valid_in;
         r_v2 <= r_v1;
      end
   end

   assign valid_out = r_v2;
   assign y_out     = r_y;

endmodule

// File: tb/tb_masked_gf16_mult_pipe.sv
// Randomized bench for masked_gf16_mult_pipe: a 2-share and a 3-share (with constant) instance
// run side by side and are compared against a bit-basis GF(16) model and an op queue.
module tb_masked_gf16_mult_pipe;

   // G(e_i, e_j) for the basis nibbles, entry i*4+j at bits [4k+3:4k].
   localparam logic [63:0] GM = 64'hB6FA_6DA5_FAE9_A597;

   typedef struct {
      int          idx;
      logic [7:0]  a2;
      logic [7:0]  b2;
      logic [3:0]  r2;
      logic [11:0] a3;
      logic [11:0] b3;
      logic [11:0] r3;
   } op_t;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        valid_in;
   logic [3:0]  c_in;
   logic [7:0]  a2, b2;
   logic [3:0]  r2;
   logic [11:0] a3, b3, r3;
   logic        v2o, v3o;
   logic [7:0]  y2;
   logic [11:0] y3;

   int n_chk = 0;
   int n_err = 0;
   int pulses = 0;
   bit phase_fixed = 1'b0;

   masked_gf16_mult_pipe #(.SHARES(2), .ADD_CONSTANT(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in),
      .a_in(a2), .b_in(b2), .r_in(r2), .c_in(c_in),
      .valid_out(v2o), .y_out(y2));

   masked_gf16_mult_pipe #(.SHARES(3), .ADD_CONSTANT(1)) dut3 (
      .clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in),
      .a_in(a3), .b_in(b3), .r_in(r3), .c_in(c_in),
      .valid_out(v3o), .y_out(y3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] ref_g(input logic [3:0] x, input logic [3:0] y);
      logic [63:0] gm;
      logic [3:0]  acc;
      gm  = GM;
      acc = 4'h0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (x[i] && y[j]) acc = acc ^ gm[4*(i*4+j) +: 4];
      return acc;
   endfunction

   function automatic int pair_idx(input int s, input int lo, input int hi);
      int k;
      k = 0;
      for (int p = 0; p < s; p++)
         for (int q = p + 1; q < s; q++) begin
            if (p == lo && q == hi) return k;
            k++;
         end
      return -1;
   endfunction

   function automatic logic [15:0] exp_shares(input int s, input logic [15:0] a, input logic [15:0] b,
                                              input logic [23:0] r, input logic [3:0] c, input bit addc);
      logic [15:0] y;
      logic [3:0]  acc;
      int          pi;
      y = 16'h0;
      for (int i = 0; i < s; i++) begin
         acc = 4'h0;
         for (int j = 0; j < s; j++) begin
            acc = acc ^ ref_g(a[4*i +: 4], b[4*j +: 4]);
            if (j != i) begin
               pi  = pair_idx(s, (i < j) ? i : j, (i < j) ? j : i);
               acc = acc ^ r[4*pi +: 4];
            end
         end
         if (i == 0 && addc) acc = acc ^ c;
         y[4*i +: 4] = acc;
      end
      return y;
   endfunction

   function automatic logic [3:0] xr2(input logic [7:0] v);
      return v[3:0] ^ v[7:4];
   endfunction

   function automatic logic [3:0] xr3(input logic [11:0] v);
      return v[3:0] ^ v[7:4] ^ v[11:8];
   endfunction

   // Model: an op issued on advance n is presented after advance n+1, using c_in of that advance.
   initial begin : monitor
      op_t         q[$];
      op_t         cur;
      op_t         o;
      logic [3:0]  cur_c;
      logic        cur_v;
      logic        rst_last;
      logic        adv_last;
      int          adv_n;
      logic        pv2, pv3;
      logic [7:0]  py2;
      logic [11:0] py3;
      logic [15:0] e;
      cur_v = 1'b0; rst_last = 1'b1; adv_last = 1'b0; adv_n = 0; cur_c = 4'h0;
      pv2 = 1'b0; pv3 = 1'b0; py2 = 8'h0; py3 = 12'h0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            q.delete();
            cur_v    = 1'b0;
            rst_last = 1'b1;
            adv_last = 1'b0;
         end else begin
            rst_last = 1'b0;
            adv_last = en;
            if (en) begin
               adv_n++;
               cur_v = 1'b0;
               if (q.size() > 0 && q[0].idx == adv_n - 1) begin
                  cur   = q.pop_front();
                  cur_c = c_in;
                  cur_v = 1'b1;
               end
               if (valid_in) begin
                  o.idx = adv_n; o.a2 = a2; o.b2 = b2; o.r2 = r2;
                  o.a3 = a3; o.b3 = b3; o.r3 = r3;
                  q.push_back(o);
               end
            end
         end
         @(negedge clk);
         if (rst_last) begin
            chk("rst_v2", {15'h0, v2o}, 16'h0);
            chk("rst_y2", {8'h0, y2}, 16'h0);
            chk("rst_v3", {15'h0, v3o}, 16'h0);
            chk("rst_y3", {4'h0, y3}, 16'h0);
         end else if (adv_last) begin
            chk("valid2", {15'h0, v2o}, {15'h0, cur_v});
            chk("valid3", {15'h0, v3o}, {15'h0, cur_v});
            if (cur_v) begin
               pulses++;
               e = exp_shares(2, {8'h0, cur.a2}, {8'h0, cur.b2}, {20'h0, cur.r2}, cur_c, 1'b0);
               chk("shares2", {8'h0, y2}, e);
               chk("recomb2", {12'h0, xr2(y2)}, {12'h0, ref_g(xr2(cur.a2), xr2(cur.b2))});
               e = exp_shares(3, {4'h0, cur.a3}, {4'h0, cur.b3}, {12'h0, cur.r3}, cur_c, 1'b1);
               chk("shares3", {4'h0, y3}, e);
               chk("recomb3", {12'h0, xr3(y3)}, {12'h0, ref_g(xr3(cur.a3), xr3(cur.b3)) ^ cur_c});
               if (phase_fixed) chk("fixed3", {12'h0, xr3(y3)}, 16'h2);
            end
         end else begin
            chk("hold_v2", {15'h0, v2o}, {15'h0, pv2});
            chk("hold_y2", {8'h0, y2}, {8'h0, py2});
            chk("hold_v3", {15'h0, v3o}, {15'h0, pv3});
            chk("hold_y3", {4'h0, y3}, {4'h0, py3});
         end
         pv2 = v2o; py2 = y2; pv3 = v3o; py3 = y3;
      end
   end

   task automatic rand_ops();
      a2 = 8'($urandom()); b2 = 8'($urandom()); r2 = 4'($urandom());
      a3 = 12'($urandom()); b3 = 12'($urandom()); r3 = 12'($urandom());
   endtask

   task automatic idle(input int n);
      valid_in = 1'b0;
      en       = 1'b1;
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin : stim
      logic [3:0] y0_a;
      logic [3:0] s0, s1;
      int         p0;
      rst_n = 1'b0; en = 1'b0; valid_in = 1'b0; c_in = 4'h0;
      a2 = 8'h0; b2 = 8'h0; r2 = 4'h0; a3 = 12'h0; b3 = 12'h0; r3 = 12'h0;
      @(negedge clk); @(negedge clk);
      chk("reset_v", {15'h0, v2o}, 16'h0);
      chk("reset_y", {4'h0, y3}, 16'h0);
      rst_n = 1'b1;
      idle(2);

      // a=(3,2), b=(5,4), r=A: recombines to G(1,1)=7
      rand_ops();
      a2 = 8'h23; b2 = 8'h45; r2 = 4'hA; valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      @(negedge clk);
      chk("t1_valid", {15'h0, v2o}, 16'h1);
      chk("t1_recomb", {12'h0, xr2(y2)}, 16'h7);

      // a=(2,0), b=(6,4), r=0 then r=F: same product E, share 0 differs by F
      rand_ops();
      a2 = 8'h02; b2 = 8'h46; r2 = 4'h0; valid_in = 1'b1;
      @(negedge clk);
      r2 = 4'hF;
      @(negedge clk);
      valid_in = 1'b0;
      y0_a = y2[3:0];
      chk("t2_recomb_a", {12'h0, xr2(y2)}, 16'hE);
      @(negedge clk);
      chk("t2_recomb_b", {12'h0, xr2(y2)}, 16'hE);
      chk("t2_y0_diff", {12'h0, y0_a ^ y2[3:0]}, 16'hF);
      idle(2);

      // 1000-cycle back-to-back stream: unmasked a=b=1, c_in=5 on the 3-share instance
      c_in = 4'h5;
      phase_fixed = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         rand_ops();
         s0 = 4'($urandom()); s1 = 4'($urandom());
         a3 = {4'h1 ^ s0 ^ s1, s1, s0};
         s0 = 4'($urandom()); s1 = 4'($urandom());
         b3 = {4'h1 ^ s0 ^ s1, s1, s0};
         valid_in = 1'b1;
         @(negedge clk);
      end
      idle(3);
      phase_fixed = 1'b0;

      // Random traffic with random stalls and a changing constant
      for (int k = 0; k < 400; k++) begin
         rand_ops();
         c_in     = 4'($urandom());
         valid_in = 1'($urandom());
         en       = ($urandom_range(3, 0) != 0);
         @(negedge clk);
      end
      idle(3);

      // Stall: three ops with one frozen cycle in the middle
      p0 = pulses;
      rand_ops(); valid_in = 1'b1; en = 1'b1;
      @(negedge clk);
      rand_ops(); en = 1'b0;
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      rand_ops();
      @(negedge clk);
      idle(4);
      chk("stall_pulses", 16'(pulses - p0), 16'd3);

      // Reset while an op is in flight
      rand_ops(); valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_v", {15'h0, v2o}, 16'h0);
      chk("rst_async_y2", {8'h0, y2}, 16'h0);
      chk("rst_async_y3", {4'h0, y3}, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      chk("rst_no_valid", {15'h0, v3o}, 16'h0);
      rand_ops(); valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      chk("rst_lat1", {15'h0, v2o}, 16'h0);
      @(negedge clk);
      chk("rst_lat2", {15'h0, v2o}, 16'h1);
      idle(2);

      // Exhaustive 2-share sweep over all (a,b) with random sharing and masks
      for (int k = 0; k < 256; k++) begin
         rand_ops();
         s0 = 4'($urandom()); s1 = 4'($urandom());
         a2 = {4'(k >> 4) ^ s0, s0};
         b2 = {4'(k) ^ s1, s1};
         valid_in = 1'b1;
         @(negedge clk);
      end
      idle(3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
